// File: rtl/ssram_pkg.sv
// Shared types for the ssram arbiter slice: default widths,
// FSM state encodings and requester ids.
package ssram_pkg;

  localparam int AW_DEF = 18;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ssram_arb_rr.sv
// Round-robin / bounded-burst grant decision for ssram_arb.
// Purely combinational: grant vector, next state and next burst count.
module ssram_arb_rr
  import ssram_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 4
) (
  input  logic          iReqA,
  input  logic          iReqB,
  input  state_t        iState,
  input  logic [CW-1:0] iCnt,
  input  logic          iLast,
  output logic [1:0]    oGnt,
  output state_t        oNxtState,
  output logic [CW-1:0] oNxtCnt
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic under;
  logic keepA;
  logic keepB;
  logic gA;
  logic gB;
  logic [CW-1:0] incCnt;

  assign under  = iCnt < MAXC;
  assign incCnt = under ? iCnt + ONE : MAXC;

  // Owner keeps the port until its burst runs out while the other waits
  assign keepA = (iState == ST_OWN_A) & iReqA & (under | ~iReqB);
  assign keepB = (iState == ST_OWN_B) & iReqB & (under | ~iReqA);

  assign gA = keepA
            | (~keepB & iReqA & (~iReqB | (iLast == REQ_B)));
  assign gB = ~gA & iReqB;

  always_comb begin
    oGnt      = 2'b00;
    oNxtState = ST_IDLE;
    oNxtCnt   = '0;
    unique case (1'b1)
      gA: begin
        oGnt      = 2'b01;
        oNxtState = ST_OWN_A;
        oNxtCnt   = keepA ? incCnt : ONE;
      end
      gB: begin
        oGnt      = 2'b10;
        oNxtState = ST_OWN_B;
        oNxtCnt   = keepB ? incCnt : ONE;
      end
      default: begin
        oGnt      = 2'b00;
        oNxtState = ST_IDLE;
        oNxtCnt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ssram_arb.sv
// Two-requester arbiter/sequencer in front of one ssram port.
// Optional grant/stall counters under SSRAM_ARB_STATS_EN.
module ssram_arb
  import ssram_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          iRst,
  input  logic          iReqA,
  input  logic          iWrA,
  input  logic [AW-1:0] iAddrA,
  input  logic [DW-1:0] iDataA,
  output logic          oGntA,
  output logic          oRdVldA,
  output logic [DW-1:0] oRdDataA,
  input  logic          iReqB,
  input  logic          iWrB,
  input  logic [AW-1:0] iAddrB,
  input  logic [DW-1:0] iDataB,
  output logic          oGntB,
  output logic          oRdVldB,
  output logic [DW-1:0] oRdDataB,
  output logic          oSramEn,
  output logic          oSramWr,
  output logic [AW-1:0] oSramAddr,
  output logic [DW-1:0] oSramData,
  input  logic [DW-1:0] iSramData
`ifdef SSRAM_ARB_STATS_EN
  ,
  output logic [15:0]   oGntCntA,
  output logic [15:0]   oGntCntB,
  output logic [15:0]   oStallCnt
`endif
);

  localparam int CW = 4;

  state_t        state;
  state_t        nxtState;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxtCnt;
  logic          last;
  logic          rdPend;
  logic          rdOwn;
  logic [1:0]    gnt;

  ssram_arb_rr #(
    .MAX_BURST(MAX_BURST),
    .CW       (CW)
  ) uRr (
    .iReqA    (iReqA),
    .iReqB    (iReqB),
    .iState   (state),
    .iCnt     (cnt),
    .iLast    (last),
    .oGnt     (gnt),
    .oNxtState(nxtState),
    .oNxtCnt  (nxtCnt)
  );

  // Grants are masked while reset is held so nothing reaches the SRAM
  assign oGntA   = gnt[0] & ~iRst;
  assign oGntB   = gnt[1] & ~iRst;
  assign oSramEn = oGntA | oGntB;

  always_comb begin
    oSramWr   = 1'b0;
    oSramAddr = '0;
    oSramData = '0;
    unique case (1'b1)
      oGntA: begin
        oSramWr   = iWrA;
        oSramAddr = iAddrA;
        oSramData = iDataA;
      end
      oGntB: begin
        oSramWr   = iWrB;
        oSramAddr = iAddrB;
        oSramData = iDataB;
      end
      default: begin
        oSramWr   = 1'b0;
        oSramAddr = '0;
        oSramData = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      last   <= REQ_B;
      rdPend <= 1'b0;
      rdOwn  <= REQ_A;
    end else begin
      state  <= nxtState;
      cnt    <= nxtCnt;
      rdPend <= oSramEn & ~oSramWr;
      if (oSramEn) last <= oGntB ? REQ_B : REQ_A;
      if (oSramEn & ~oSramWr) rdOwn <= oGntB ? REQ_B : REQ_A;
    end
  end

  assign oRdVldA  = rdPend & (rdOwn == REQ_A);
  assign oRdVldB  = rdPend & (rdOwn == REQ_B);
  assign oRdDataA = oRdVldA ? iSramData : '0;
  assign oRdDataB = oRdVldB ? iSramData : '0;

`ifdef SSRAM_ARB_STATS_EN
  logic stall;

  assign stall = (iReqA & ~oGntA) | (iReqB & ~oGntB);

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      oGntCntA  <= '0;
      oGntCntB  <= '0;
      oStallCnt <= '0;
    end else begin
      if (oGntA) oGntCntA <= oGntCntA + 16'd1;
      if (oGntB) oGntCntB <= oGntCntB + 16'd1;
      if (stall && oStallCnt != 16'hFFFF)
        oStallCnt <= oStallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ssram_arb.sv
// Directed bench for ssram_arb with a behavioural one-cycle SRAM.
// Table of single-cycle vectors plus hand-written corner sequences.
module tb_ssram_arb;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk;
  logic          iRst;
  logic          iReqA, iWrA, iReqB, iWrB;
  logic [AW-1:0] iAddrA, iAddrB;
  logic [DW-1:0] iDataA, iDataB;
  logic          oGntA, oRdVldA, oGntB, oRdVldB;
  logic [DW-1:0] oRdDataA, oRdDataB;
  logic          oSramEn, oSramWr;
  logic [AW-1:0] oSramAddr;
  logic [DW-1:0] oSramData, iSramData;
`ifdef SSRAM_ARB_STATS_EN
  logic [15:0]   oGntCntA, oGntCntB, oStallCnt;
`endif

  int nChecks = 0;
  int nFail   = 0;

  ssram_arb #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk      (clk),
    .iRst     (iRst),
    .iReqA    (iReqA),
    .iWrA     (iWrA),
    .iAddrA   (iAddrA),
    .iDataA   (iDataA),
    .oGntA    (oGntA),
    .oRdVldA  (oRdVldA),
    .oRdDataA (oRdDataA),
    .iReqB    (iReqB),
    .iWrB     (iWrB),
    .iAddrB   (iAddrB),
    .iDataB   (iDataB),
    .oGntB    (oGntB),
    .oRdVldB  (oRdVldB),
    .oRdDataB (oRdDataB),
    .oSramEn  (oSramEn),
    .oSramWr  (oSramWr),
    .oSramAddr(oSramAddr),
    .oSramData(oSramData),
    .iSramData(iSramData)
`ifdef SSRAM_ARB_STATS_EN
    ,
    .oGntCntA (oGntCntA),
    .oGntCntB (oGntCntB),
    .oStallCnt(oStallCnt)
`endif
  );

  // Behavioural ssram: registered read address, one-cycle latency
  logic [DW-1:0] mem [256];
  logic [7:0]    rAddr;

  always @(posedge clk) begin
    if (oSramEn) begin
      if (oSramWr) mem[oSramAddr[7:0]] <= oSramData;
      else rAddr <= oSramAddr[7:0];
    end
  end
  assign iSramData = mem[rAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          reqA, wrA;
    logic [AW-1:0] addrA;
    logic [DW-1:0] dataA;
    logic          reqB, wrB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] dataB;
    logic          gA, gB, vA, vB;
    logic [DW-1:0] rdA, rdB;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idleIn();
    iReqA = 0; iWrA = 0; iAddrA = '0; iDataA = '0;
    iReqB = 0; iWrB = 0; iAddrB = '0; iDataB = '0;
  endtask

  task automatic doReset();
    idleIn();
    iRst = 1'b1;
    @(posedge clk);
    #1 iRst = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
    input logic ga, gb, va, vb, input logic [DW-1:0] xa, xb);
    vec_t v;
    v.reqA = ra; v.wrA = wa; v.addrA = aa; v.dataA = da;
    v.reqB = rb; v.wrB = wb; v.addrB = ab; v.dataB = db;
    v.gA = ga; v.gB = gb; v.vA = va; v.vB = vb;
    v.rdA = xa; v.rdB = xb;
    return v;
  endfunction

  initial begin
    logic [AW-1:0] expAddr;
    logic          expA;
    string         pat;

    vecs[0]  = mk(1,1,'h10,'hDEADBEEF, 0,0,0,0,   1,0,0,0, 0,0);
    vecs[1]  = mk(1,0,'h10,0,          0,0,0,0,   1,0,0,0, 0,0);
    vecs[2]  = mk(0,0,0,0,             0,0,0,0,   0,0,1,0, 'hDEADBEEF,0);
    vecs[3]  = mk(1,1,'h3,'h5,         0,0,0,0,   1,0,0,0, 0,0);
    vecs[4]  = mk(0,0,0,0,             1,0,'h3,0, 0,1,0,0, 0,0);
    vecs[5]  = mk(0,0,0,0,             0,0,0,0,   0,0,0,1, 0,'h5);
    vecs[6]  = mk(1,0,'h3,0,   1,1,'h20,'h1234,   1,0,0,0, 0,0);
    vecs[7]  = mk(0,0,0,0,     1,1,'h20,'h1234,   0,1,1,0, 'h5,0);
    vecs[8]  = mk(1,0,'h20,0,  1,0,'h10,0,        0,1,0,0, 0,0);
    vecs[9]  = mk(1,0,'h20,0,  0,0,0,0,           1,0,0,1, 0,'hDEADBEEF);
    vecs[10] = mk(0,0,0,0,     0,0,0,0,           0,0,1,0, 'h1234,0);

    // Reset: outputs stay quiet even with requests present
    iRst = 1'b1;
    idleIn();
    iReqA = 1; iWrA = 1; iAddrA = 'h5; iDataA = 'hA5A5;
    iReqB = 1;
    #2;
    chk("rst_gntA", oGntA, 0);
    chk("rst_gntB", oGntB, 0);
    chk("rst_en", oSramEn, 0);
    chk("rst_wr", oSramWr, 0);
    chk("rst_addr", oSramAddr, 0);
    chk("rst_data", oSramData, 0);
    chk("rst_vldA", oRdVldA, 0);
    chk("rst_vldB", oRdVldB, 0);
    @(posedge clk);
    #1 doReset();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      iReqA = vecs[i].reqA; iWrA = vecs[i].wrA;
      iAddrA = vecs[i].addrA; iDataA = vecs[i].dataA;
      iReqB = vecs[i].reqB; iWrB = vecs[i].wrB;
      iAddrB = vecs[i].addrB; iDataB = vecs[i].dataB;
      expAddr = vecs[i].gA ? vecs[i].addrA :
                vecs[i].gB ? vecs[i].addrB : '0;
      @(negedge clk);
      chk($sformatf("v%0d_gntA", i), oGntA, vecs[i].gA);
      chk($sformatf("v%0d_gntB", i), oGntB, vecs[i].gB);
      chk($sformatf("v%0d_en", i), oSramEn, vecs[i].gA | vecs[i].gB);
      chk($sformatf("v%0d_addr", i), oSramAddr, expAddr);
      chk($sformatf("v%0d_vldA", i), oRdVldA, vecs[i].vA);
      chk($sformatf("v%0d_vldB", i), oRdVldB, vecs[i].vB);
      chk($sformatf("v%0d_rdA", i), oRdDataA, vecs[i].rdA);
      chk($sformatf("v%0d_rdB", i), oRdDataB, vecs[i].rdB);
      @(posedge clk);
      #1;
    end
    idleIn();

    // Contention: both held from reset gives AAAABBBBAAAA
    doReset();
    pat = "AAAABBBBAAAA";
    iReqA = 1; iAddrA = 'h40;
    iReqB = 1; iAddrB = 'h41;
    for (int c = 0; c < 12; c++) begin
      expA = (pat[c] == "A");
      @(negedge clk);
      chk($sformatf("rr%0d_gntA", c), oGntA, expA);
      chk($sformatf("rr%0d_gntB", c), oGntB, !expA);
      @(posedge clk);
      #1;
    end
    idleIn();
    @(negedge clk);
`ifdef SSRAM_ARB_STATS_EN
    chk("stat_gntA", oGntCntA, 8);
    chk("stat_gntB", oGntCntB, 4);
    chk("stat_stall", oStallCnt, 12);
`endif
    @(posedge clk);
    #1;

    // A alone for 10 cycles: no burst limit applies
    doReset();
    iReqA = 1; iAddrA = 'h7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("solo%0d_gntA", c), oGntA, 1);
      @(posedge clk);
      #1;
    end
    // Burst count is saturated, so B takes over at once
    iReqB = 1; iAddrB = 'h8;
    @(negedge clk);
    chk("solo_handoff_gntB", oGntB, 1);
    chk("solo_handoff_gntA", oGntA, 0);
    @(posedge clk);
    #1 idleIn();

    // Reset between a granted read and its return
    doReset();
    iReqA = 1; iAddrA = 'h10;
    @(negedge clk);
    chk("mid_gntA", oGntA, 1);
    @(posedge clk);
    #1 idleIn();
    iRst = 1'b1;
    #1;
    chk("mid_vldA_rst", oRdVldA, 0);
    chk("mid_rdA_rst", oRdDataA, 0);
    #1 iRst = 1'b0;
    @(negedge clk);
    chk("mid_vldA", oRdVldA, 0);
    chk("mid_en", oSramEn, 0);
    @(posedge clk);
    #1;
    iReqA = 1; iAddrA = 'h1;
    iReqB = 1; iAddrB = 'h2;
    @(negedge clk);
    chk("mid_tie_gntA", oGntA, 1);
    chk("mid_tie_gntB", oGntB, 0);
    @(posedge clk);
    #1 idleIn();
    @(negedge clk);
    chk("end_vldB", oRdVldB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
